// File: rtl/register_file.sv
// Datapath register file: four data registers R1..R4 and four temporaries T1..T4 sharing
// one clear/load/decrement/increment operation per clock, with two combinational read ports.
module register_file #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       TSel,
  input  logic [2:0]       O1Sel,
  input  logic [2:0]       O2Sel,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2
);

  localparam logic [1:0] FUN_CLEAR = 2'b00;
  localparam logic [1:0] FUN_LOAD  = 2'b01;
  localparam logic [1:0] FUN_DEC   = 2'b10;
  localparam logic [1:0] FUN_INC   = 2'b11;

  // Storage is indexed by read-select code: 0..3 = T1..T4, 4..7 = R1..R4.
  logic [WIDTH-1:0] r_regs [8];
  logic [7:0]       w_en;

  assign w_en = {RegSel[0], RegSel[1], RegSel[2], RegSel[3],
                 TSel[0],   TSel[1],   TSel[2],   TSel[3]};

  // One register cell per entry; each operates on its own old value.
  for (genvar g = 0; g < 8; g++) begin : g_cell
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_regs[g] <= '0;
      end else if (w_en[g]) begin
        case (FunSel)
          FUN_CLEAR: r_regs[g] <= '0;
          FUN_LOAD:  r_regs[g] <= I;
          FUN_DEC:   r_regs[g] <= r_regs[g] - 1'b1;
          FUN_INC:   r_regs[g] <= r_regs[g] + 1'b1;
          default:   r_regs[g] <= r_regs[g];
        endcase
      end
    end
  end

  assign O1 = r_regs[O1Sel];
  assign O2 = r_regs[O2Sel];

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: vector table plus hand-written sequences
// for asynchronous reset and same-cycle read-before-write behaviour.
`timescale 1ns/1ps
module tb_register_file;

  logic       CLK;
  logic       RSTn;
  logic [7:0] I;
  logic [1:0] FunSel;
  logic [3:0] RegSel;
  logic [3:0] TSel;
  logic [2:0] O1Sel;
  logic [2:0] O2Sel;
  logic [7:0] O1;
  logic [7:0] O2;

  int tests_run;
  int tests_failed;

  // exp[k] is the expected content of read code k (0..3 = T1..T4, 4..7 = R1..R4).
  typedef struct {
    string           name;
    logic [1:0]      fs;
    logic [3:0]      rs;
    logic [3:0]      ts;
    logic [7:0]      din;
    logic [7:0][7:0] exp;
  } vec_t;

  vec_t vecs[$];

  register_file #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .I      (I),
    .FunSel (FunSel),
    .RegSel (RegSel),
    .TSel   (TSel),
    .O1Sel  (O1Sel),
    .O2Sel  (O2Sel),
    .O1     (O1),
    .O2     (O2)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic add_vec(input string name, input logic [1:0] fs, input logic [3:0] rs,
                         input logic [3:0] ts, input logic [7:0] din,
                         input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3,
                         input logic [7:0] t4, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] r3, input logic [7:0] r4);
    vec_t v;
    v.name = name;
    v.fs   = fs;
    v.rs   = rs;
    v.ts   = ts;
    v.din  = din;
    v.exp  = {r4, r3, r2, r1, t4, t3, t2, t1};
    vecs.push_back(v);
  endtask

  task automatic go_idle();
    RegSel = 4'b0000;
    TSel   = 4'b0000;
  endtask

  task automatic check_one(input string name, input logic [7:0] act, input logic [7:0] exp,
                           input int code);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s code=%0d got=%h expected=%h", name, code, act, exp);
    end
  endtask

  // Sweep both read ports over all codes; O2 walks in reverse so the ports differ.
  task automatic check_all(input string name, input logic [7:0][7:0] exp);
    for (int c = 0; c < 8; c++) begin
      O1Sel = 3'(c);
      O2Sel = 3'(7 - c);
      #0.2;
      check_one({name, ".O1"}, O1, exp[c], c);
      check_one({name, ".O2"}, O2, exp[7 - c], 7 - c);
    end
    O2Sel = 3'd5;
    O1Sel = 3'd5;
    #0.2;
    check_one({name, ".same_sel"}, O2, O1, 5);
  endtask

  // ---------------- scoreboard / stimulus ----------------
  initial begin
    logic [7:0][7:0] zeros;
    logic [7:0][7:0] st;
    tests_run    = 0;
    tests_failed = 0;
    zeros        = '0;

    //        name         fs     rs       ts       I      T1    T2    T3    T4    R1    R2    R3    R4
    add_vec("load_all",   2'b01, 4'b1111, 4'b1111, 8'hAA, 8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'hAA);
    add_vec("clr_r2",     2'b00, 4'b0100, 4'b0000, 8'h11, 8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'h00,8'hAA,8'hAA);
    add_vec("dec_r2_wrap",2'b10, 4'b0100, 4'b0000, 8'h11, 8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'hFF,8'hAA,8'hAA);
    add_vec("inc_r2_wrap",2'b11, 4'b0100, 4'b0000, 8'h11, 8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'h00,8'hAA,8'hAA);
    add_vec("inc_r2",     2'b11, 4'b0100, 4'b0000, 8'h11, 8'hAA,8'hAA,8'hAA,8'hAA,8'hAA,8'h01,8'hAA,8'hAA);
    add_vec("load_t4",    2'b01, 4'b0000, 4'b0001, 8'hFF, 8'hAA,8'hAA,8'hAA,8'hFF,8'hAA,8'h01,8'hAA,8'hAA);
    add_vec("inc_t4_wrap",2'b11, 4'b0000, 4'b0001, 8'h22, 8'hAA,8'hAA,8'hAA,8'h00,8'hAA,8'h01,8'hAA,8'hAA);
    add_vec("load_t123",  2'b01, 4'b0000, 4'b1110, 8'h55, 8'h55,8'h55,8'h55,8'h00,8'hAA,8'h01,8'hAA,8'hAA);
    add_vec("clr_t123",   2'b00, 4'b0000, 4'b1110, 8'h55, 8'h00,8'h00,8'h00,8'h00,8'hAA,8'h01,8'hAA,8'hAA);
    add_vec("sel_load",   2'b01, 4'b1000, 4'b0010, 8'h3C, 8'h00,8'h00,8'h3C,8'h00,8'h3C,8'h01,8'hAA,8'hAA);
    add_vec("idle_clr",   2'b00, 4'b0000, 4'b0000, 8'h77, 8'h00,8'h00,8'h3C,8'h00,8'h3C,8'h01,8'hAA,8'hAA);
    add_vec("idle_load",  2'b01, 4'b0000, 4'b0000, 8'h77, 8'h00,8'h00,8'h3C,8'h00,8'h3C,8'h01,8'hAA,8'hAA);
    add_vec("idle_dec",   2'b10, 4'b0000, 4'b0000, 8'h77, 8'h00,8'h00,8'h3C,8'h00,8'h3C,8'h01,8'hAA,8'hAA);
    add_vec("idle_inc",   2'b11, 4'b0000, 4'b0000, 8'h77, 8'h00,8'h00,8'h3C,8'h00,8'h3C,8'h01,8'hAA,8'hAA);
    add_vec("mix_inc",    2'b11, 4'b0011, 4'b1001, 8'h77, 8'h01,8'h00,8'h3C,8'h01,8'h3C,8'h01,8'hAB,8'hAB);
    add_vec("mix_dec",    2'b10, 4'b0001, 4'b0100, 8'h77, 8'h01,8'hFF,8'h3C,8'h01,8'h3C,8'h01,8'hAB,8'hAA);

    // Reset with an active load pending: it must win.
    RSTn   = 1'b0;
    I      = 8'hC3;
    FunSel = 2'b01;
    RegSel = 4'b1111;
    TSel   = 4'b1111;
    O1Sel  = '0;
    O2Sel  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset_init", zeros);
    @(negedge CLK);
    go_idle();
    RSTn = 1'b1;

    // Table: drive at negedge, one active edge, then idle and sweep both ports.
    st = zeros;
    foreach (vecs[n]) begin
      @(negedge CLK);
      FunSel = vecs[n].fs;
      RegSel = vecs[n].rs;
      TSel   = vecs[n].ts;
      I      = vecs[n].din;
      @(posedge CLK);
      #1;
      go_idle();
      check_all(vecs[n].name, vecs[n].exp);
      st = vecs[n].exp;
    end

    // Same-cycle read: old value until the edge, new value right after it.
    @(negedge CLK);
    O1Sel  = 3'b100;
    O2Sel  = 3'b100;
    FunSel = 2'b11;
    RegSel = 4'b1000;
    #4;
    check_one("rd_before_edge", O1, 8'h3C, 4);
    @(posedge CLK);
    #0.1;
    check_one("rd_after_edge", O2, 8'h3D, 4);
    go_idle();
    st[4] = 8'h3D;
    check_all("after_rd_test", st);

    // Asynchronous reset mid-cycle with a load armed: clears immediately, no edge needed.
    @(negedge CLK);
    FunSel = 2'b01;
    I      = 8'h99;
    RegSel = 4'b1111;
    TSel   = 4'b1111;
    #2;
    RSTn = 1'b0;
    #0.5;
    O1Sel = 3'b101;
    O2Sel = 3'b010;
    #0.1;
    check_one("async_rst_o1", O1, 8'h00, 5);
    check_one("async_rst_o2", O2, 8'h00, 2);
    check_all("async_rst_all", zeros);
    @(posedge CLK);
    #1;
    check_all("rst_held", zeros);
    @(negedge CLK);
    RSTn = 1'b1;
    go_idle();
    @(posedge CLK);
    #1;
    check_all("rst_released_idle", zeros);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
